// File: rtl/midi_stream_parser.sv
// MIDI byte-stream parser: decodes channel-voice messages with running status,
// forwards real-time bytes, filters channels, aborts stalled messages and counts errors.
module midi_stream_parser #(
  parameter logic [15:0] CHAN_MASK     = 16'hFFFF,
  parameter bit          NOTEON_V0_OFF = 1'b1,
  parameter logic [19:0] TIMEOUT_CYC   = 20'd32000,
  parameter int          ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             ev_valid,
  output logic [2:0]       ev_type,
  output logic [3:0]       ev_channel,
  output logic [6:0]       ev_data1,
  output logic [6:0]       ev_data2,
  output logic             rt_valid,
  output logic [7:0]       rt_byte,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;

  state_t      state, state_n;
  logic [7:0]  rs, rs_n;
  logic        rs_ok, rs_ok_n;
  logic [6:0]  d1, d1_n;
  logic [19:0] tcnt, tcnt_n;
  logic        err_inc, emit, rt_fire;
  logic [6:0]  emit_d1, emit_d2;
  logic        one_byte;
  logic        is_rt;

  assign one_byte = (rs[6:4] == 3'd4) || (rs[6:4] == 3'd5);
  assign is_rt    = in_valid && (in_data[7:3] == 5'b11111);
  assign busy     = (state == WAIT_D2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rs    <= '0;
      rs_ok <= 1'b0;
      d1    <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      rs    <= rs_n;
      rs_ok <= rs_ok_n;
      d1    <= d1_n;
      tcnt  <= tcnt_n;
    end
  end

  // F8..FE leave parser state alone, so a stalled message can still time out under them.
  always_comb begin
    state_n = state;
    rs_n    = rs;
    rs_ok_n = rs_ok;
    d1_n    = d1;
    tcnt_n  = tcnt;
    err_inc = 1'b0;
    emit    = 1'b0;
    emit_d1 = d1;
    emit_d2 = '0;
    rt_fire = is_rt;
    if (in_valid && in_data == 8'hFF) begin
      rs_ok_n = 1'b0;
      state_n = IDLE;
      tcnt_n  = '0;
    end else if (in_valid && !is_rt) begin
      tcnt_n = '0;
      if (in_data[7]) begin
        if (state == WAIT_D2) err_inc = 1'b1;
        if (in_data[7:4] != 4'hF) begin
          rs_n    = in_data;
          rs_ok_n = 1'b1;
          state_n = WAIT_D1;
        end else begin
          rs_ok_n = 1'b0;
          state_n = (in_data == 8'hF7) ? IDLE : SKIP;
        end
      end else begin
        case (state)
          IDLE: err_inc = 1'b1;
          SKIP: err_inc = 1'b0;
          WAIT_D1: begin
            if (!rs_ok) begin
              err_inc = 1'b1;
            end else begin
              d1_n    = in_data[6:0];
              emit_d1 = in_data[6:0];
              if (one_byte) emit = 1'b1;
              else          state_n = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d2 = in_data[6:0];
            state_n = WAIT_D1;
          end
          default: state_n = IDLE;
        endcase
      end
    end else if (state == WAIT_D2 && TIMEOUT_CYC != 20'd0) begin
      if (tcnt == TIMEOUT_CYC) begin
        state_n = WAIT_D1;
        d1_n    = '0;
        tcnt_n  = '0;
        err_inc = 1'b1;
      end else begin
        tcnt_n = tcnt + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid   <= 1'b0;
      ev_type    <= '0;
      ev_channel <= '0;
      ev_data1   <= '0;
      ev_data2   <= '0;
      rt_valid   <= 1'b0;
      rt_byte    <= '0;
      err_count  <= '0;
    end else begin
      ev_valid <= 1'b0;
      rt_valid <= 1'b0;
      if (rt_fire) begin
        rt_valid <= 1'b1;
        rt_byte  <= in_data;
      end
      if (emit && CHAN_MASK[rs[3:0]]) begin
        ev_valid   <= 1'b1;
        ev_channel <= rs[3:0];
        ev_data1   <= emit_d1;
        ev_data2   <= emit_d2;
        if (NOTEON_V0_OFF && rs[6:4] == 3'd1 && emit_d2 == 7'd0) ev_type <= 3'd0;
        else                                                      ev_type <= rs[6:4];
      end
      if (err_inc && err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_midi_stream_parser.sv
// Scoreboard bench for midi_stream_parser: expected events are queued as bytes are
// driven and compared when the parser pulses ev_valid / rt_valid.
module tb_midi_stream_parser;

  localparam logic [15:0] MASK = 16'h7FFF;
  localparam logic [19:0] TMO  = 20'd40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ev_valid, rt_valid, busy;
  logic [2:0] ev_type;
  logic [3:0] ev_channel;
  logic [6:0] ev_data1, ev_data2;
  logic [7:0] rt_byte;
  logic [7:0] err_count;

  typedef struct {
    logic [2:0] t;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] rtq[$];
  int         checkCount = 0;
  int         passCount  = 0;

  midi_stream_parser #(
    .CHAN_MASK(MASK), .NOTEON_V0_OFF(1'b1), .TIMEOUT_CYC(TMO), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .ev_valid(ev_valid), .ev_type(ev_type), .ev_channel(ev_channel),
    .ev_data1(ev_data1), .ev_data2(ev_data2), .rt_valid(rt_valid),
    .rt_byte(rt_byte), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic expectEvent(input logic [2:0] t, input logic [3:0] ch,
                             input logic [6:0] d1, input logic [6:0] d2);
    ev_t e;
    e.t = t; e.ch = ch; e.d1 = d1; e.d2 = d2;
    evq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    if (b >= 8'hF8) rtq.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ev_valid) begin
      if (evq.size() == 0) begin
        checkOutput("ev_unexpected", 32'd1, 32'd0);
      end else begin
        ev_t e;
        e = evq.pop_front();
        checkOutput("ev_type", ev_type, e.t);
        checkOutput("ev_channel", ev_channel, e.ch);
        checkOutput("ev_data1", ev_data1, e.d1);
        checkOutput("ev_data2", ev_data2, e.d2);
      end
    end
    if (rt_valid) begin
      if (rtq.size() == 0) checkOutput("rt_unexpected", 32'd1, 32'd0);
      else                 checkOutput("rt_byte", rt_byte, rtq.pop_front());
    end
  end

  task automatic checkDrained(input string tag);
    idle(3);
    checkOutput({tag, "_evq"}, evq.size(), 0);
    checkOutput({tag, "_rtq"}, rtq.size(), 0);
    evq.delete();
    rtq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #23;
    checkOutput("rst_ev_valid", ev_valid, 0);
    checkOutput("rst_rt_valid", rt_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_fields", {ev_type, ev_channel, ev_data1, ev_data2, rt_byte}, 0);
    @(negedge clk); rst = 1'b1;
    idle(2);

    // Basic Note On, busy between data bytes
    applyStimulus(8'h90);
    applyStimulus(8'h3C);
    checkOutput("t1_busy_mid", busy, 1);
    expectEvent(3'd1, 4'd0, 7'h3C, 7'h64);
    applyStimulus(8'h64);
    checkOutput("t1_busy_end", busy, 0);
    checkDrained("t1");

    // Running status with Note On velocity 0 mapped to Note Off
    expectEvent(3'd1, 4'd3, 7'h40, 7'h7F);
    expectEvent(3'd0, 4'd3, 7'h41, 7'h00);
    applyStimulus(8'h93); applyStimulus(8'h40); applyStimulus(8'h7F);
    applyStimulus(8'h41); applyStimulus(8'h00);
    checkDrained("t2");

    // One-byte messages with running status
    expectEvent(3'd4, 4'd5, 7'h07, 7'h00);
    expectEvent(3'd4, 4'd5, 7'h09, 7'h00);
    applyStimulus(8'hC5); applyStimulus(8'h07); applyStimulus(8'h09);
    checkDrained("t3");
    checkOutput("t3_err", err_count, 0);

    // Real-time byte inside a message
    expectEvent(3'd1, 4'd0, 7'h3C, 7'h64);
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'hF8);
    checkOutput("t4_busy_rt", busy, 1);
    applyStimulus(8'h64);
    checkDrained("t4");

    // Timeout aborts the stalled message, rs is kept
    applyStimulus(8'hE0); applyStimulus(8'h00);
    idle(int'(TMO) + 10);
    checkOutput("t5_err", err_count, 1);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_no_ev", evq.size(), 0);
    expectEvent(3'd6, 4'd0, 7'h10, 7'h20);
    applyStimulus(8'h10); applyStimulus(8'h20);
    checkDrained("t5");

    // SysEx skip, then stray data in IDLE
    applyStimulus(8'hF0); applyStimulus(8'h12); applyStimulus(8'h34);
    applyStimulus(8'hF7); applyStimulus(8'h45);
    checkDrained("t6");
    checkOutput("t6_err", err_count, 2);

    // Masked channel 15 completes silently
    applyStimulus(8'h8F); applyStimulus(8'h3C); applyStimulus(8'h00);
    checkDrained("t7");
    checkOutput("t7_err", err_count, 2);

    // FF drops the partial message without error; following data hits IDLE
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'hFF);
    checkOutput("t8_busy", busy, 0);
    checkOutput("t8_err_ff", err_count, 2);
    applyStimulus(8'h40);
    checkOutput("t8_err_data", err_count, 3);
    checkDrained("t8");

    // Interrupted message counts an error; new status proceeds
    applyStimulus(8'h91); applyStimulus(8'h3C); applyStimulus(8'h92);
    checkOutput("t9_err", err_count, 4);
    expectEvent(3'd1, 4'd2, 7'h10, 7'h20);
    applyStimulus(8'h10); applyStimulus(8'h20);
    checkDrained("t9");

    // Asynchronous reset mid-message loses everything
    applyStimulus(8'h90); applyStimulus(8'h3C);
    #2 rst = 1'b0;
    #1;
    checkOutput("t10_busy_rst", busy, 0);
    checkOutput("t10_err_rst", err_count, 0);
    @(negedge clk); rst = 1'b1;
    applyStimulus(8'h64);
    checkOutput("t10_err_idle", err_count, 1);
    checkDrained("t10");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
